// File: rtl/regfile_pkg.sv
// Shared constants and types for the 16x16 register file.
package regfile_pkg;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = $clog2(DEPTH);

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic {
        IDLE,
        CLEAR
    } rf_state_t;

endpackage

// File: rtl/register_file_16_clear_sequencer.sv
// Sweeps the register file to zero, one entry per cycle.
module clear_sequencer
    import regfile_pkg::*;
(
    input  logic  Clk,
    input  logic  Reset_n,
    input  logic  i_clr,
    output logic  o_busy,
    output logic  o_clr_we,
    output addr_t o_clr_addr
);

    rf_state_t r_state;
    rf_state_t w_state_nxt;
    addr_t     r_ptr;
    addr_t     w_ptr_nxt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        unique case (r_state)
            IDLE: begin
                if (i_clr) begin
                    w_state_nxt = CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            CLEAR: begin
                w_ptr_nxt = r_ptr + 1'b1;
                // Last entry zeroed on this edge; Clr is ignored mid-sweep.
                if (r_ptr == addr_t'(DEPTH - 1)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    assign o_busy     = (r_state == CLEAR);
    assign o_clr_we   = (r_state == CLEAR);
    assign o_clr_addr = r_ptr;

endmodule

// File: rtl/register_file_16.sv
// 16x16 register file: two registered read ports with write-first
// bypass, plus a sequenced clear driven by clear_sequencer.
module register_file_16
    import regfile_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              W_en,
    input  logic [ADDR_W-1:0] W_addr,
    input  logic [DATA_W-1:0] W_data,
    input  logic              Ra_en,
    input  logic [ADDR_W-1:0] Ra_addr,
    input  logic              Rb_en,
    input  logic [ADDR_W-1:0] Rb_addr,
    input  logic              Clr,
    output logic [DATA_W-1:0] Ra_data,
    output logic [DATA_W-1:0] Rb_data,
    output logic              Busy
);

    data_t r_mem [DEPTH];
    data_t r_ra;
    data_t r_rb;

    logic  w_busy;
    logic  w_clr_we;
    addr_t w_clr_addr;
    logic  w_we;
    addr_t w_waddr;
    data_t w_wdata;

    clear_sequencer u_clr_seq (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .i_clr     (Clr),
        .o_busy    (w_busy),
        .o_clr_we  (w_clr_we),
        .o_clr_addr(w_clr_addr)
    );

    // The sweep owns the write port; external writes are dropped.
    assign w_we    = w_clr_we | (W_en & ~w_busy);
    assign w_waddr = w_clr_we ? w_clr_addr : W_addr;
    assign w_wdata = w_clr_we ? '0 : W_data;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_ra <= '0;
            r_rb <= '0;
        end else begin
            if (w_we) begin
                r_mem[w_waddr] <= w_wdata;
            end
            if (Ra_en) begin
                r_ra <= (w_we && (w_waddr == Ra_addr)) ? w_wdata : r_mem[Ra_addr];
            end
            if (Rb_en) begin
                r_rb <= (w_we && (w_waddr == Rb_addr)) ? w_wdata : r_mem[Rb_addr];
            end
        end
    end

    assign Ra_data = r_ra;
    assign Rb_data = r_rb;
    assign Busy    = w_busy;

endmodule

// File: tb/tb_register_file_16.sv
// Randomized + directed self-checking bench for register_file_16.
module tb_register_file_16;

    logic        Clk;
    logic        Reset_n;
    logic        W_en;
    logic [3:0]  W_addr;
    logic [15:0] W_data;
    logic        Ra_en;
    logic [3:0]  Ra_addr;
    logic        Rb_en;
    logic [3:0]  Rb_addr;
    logic        Clr;
    logic [15:0] Ra_data;
    logic [15:0] Rb_data;
    logic        Busy;

    int checks   = 0;
    int failures = 0;
    logic run = 1'b0;

    register_file_16 dut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .W_en   (W_en),
        .W_addr (W_addr),
        .W_data (W_data),
        .Ra_en  (Ra_en),
        .Ra_addr(Ra_addr),
        .Rb_en  (Rb_en),
        .Rb_addr(Rb_addr),
        .Clr    (Clr),
        .Ra_data(Ra_data),
        .Rb_data(Rb_data),
        .Busy   (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: array contents, read latches, cycles of sweep left.
    logic [15:0] m_mem [16];
    logic [15:0] m_ra;
    logic [15:0] m_rb;
    int          m_left;

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < 16; i++) m_mem[i] = 16'h0;
            m_ra   = 16'h0;
            m_rb   = 16'h0;
            m_left = 0;
        end else begin
            if (m_left > 0) begin
                m_mem[16 - m_left] = 16'h0;
                if (Ra_en) m_ra = m_mem[Ra_addr];
                if (Rb_en) m_rb = m_mem[Rb_addr];
                m_left = m_left - 1;
            end else begin
                if (W_en) m_mem[W_addr] = W_data;
                if (Ra_en) m_ra = m_mem[Ra_addr];
                if (Rb_en) m_rb = m_mem[Rb_addr];
                if (Clr) m_left = 16;
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (run) begin
            chk("model_ra", Ra_data, m_ra);
            chk("model_rb", Rb_data, m_rb);
            chk("model_busy", {15'h0, Busy}, {15'h0, m_left > 0});
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        W_en = 0; W_addr = 0; W_data = 0;
        Ra_en = 0; Ra_addr = 0; Rb_en = 0; Rb_addr = 0; Clr = 0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (Busy && n < 40) begin
            step();
            n++;
        end
        chk(nm, {15'h0, Busy}, 16'h0);
    endtask

    initial begin
        int n;
        Reset_n = 1'b0;
        idle_inputs();
        step();
        step();
        chk("reset_ra", Ra_data, 16'h0);
        chk("reset_rb", Rb_data, 16'h0);
        chk("reset_busy", {15'h0, Busy}, 16'h0);
        Reset_n = 1'b1;
        run = 1'b1;
        step();

        W_en = 1; W_addr = 3; W_data = 16'h00F7;
        step();
        W_en = 0; Ra_en = 1; Ra_addr = 3;
        step();
        chk("rd_after_wr_a", Ra_data, 16'h00F7);
        chk("rd_after_wr_b", Rb_data, 16'h0);

        W_en = 1; W_addr = 5; W_data = 16'h1234;
        Ra_en = 1; Ra_addr = 5; Rb_en = 1; Rb_addr = 5;
        step();
        chk("bypass_a", Ra_data, 16'h1234);
        chk("bypass_b", Rb_data, 16'h1234);

        idle_inputs();
        Ra_en = 1; Ra_addr = 3;
        step();
        chk("reread_a", Ra_data, 16'h00F7);
        Ra_en = 0; W_en = 1; W_addr = 3; W_data = 16'hAAAA;
        step();
        W_en = 0;
        step();
        chk("hold_a", Ra_data, 16'h00F7);
        Ra_en = 1;
        step();
        chk("reassert_a", Ra_data, 16'hAAAA);

        idle_inputs();
        for (int i = 0; i < 16; i++) begin
            W_en = 1; W_addr = 4'(i); W_data = 16'(i + 1);
            step();
        end
        idle_inputs();
        Clr = 1;
        step();
        Clr = 0;
        n = 0;
        while (Busy && n < 40) begin
            n++;
            if (n == 1) begin
                W_en = 1; W_addr = 7; W_data = 16'h7777;
                Ra_en = 1; Ra_addr = 7;
            end
            if (n == 2) begin
                W_en = 0; Ra_en = 0;
                chk("sweep_wr_dropped", Ra_data, 16'h0008);
            end
            step();
        end
        chk("busy_cycles", 16'(n), 16'd16);
        for (int i = 0; i < 16; i += 2) begin
            Ra_en = 1; Ra_addr = 4'(i); Rb_en = 1; Rb_addr = 4'(i + 1);
            step();
            chk("cleared_a", Ra_data, 16'h0);
            chk("cleared_b", Rb_data, 16'h0);
        end

        idle_inputs();
        W_en = 1; W_addr = 1; W_data = 16'h5555;
        Ra_en = 1; Ra_addr = 1;
        step();
        idle_inputs();
        Clr = 1;
        step();
        Clr = 0;
        repeat (5) step();
        chk("pre_reset_busy", {15'h0, Busy}, 16'h1);
        #3 Reset_n = 1'b0;
        #1;
        chk("async_rst_busy", {15'h0, Busy}, 16'h0);
        chk("async_rst_ra", Ra_data, 16'h0);
        step();
        Reset_n = 1'b1;
        step();
        W_en = 1; W_addr = 2; W_data = 16'h0042;
        step();
        W_en = 0; Ra_en = 1; Ra_addr = 2;
        step();
        chk("post_reset_rd", Ra_data, 16'h0042);

        idle_inputs();
        Clr = 1; W_en = 1; W_addr = 9; W_data = 16'hBEEF;
        step();
        idle_inputs();
        wait_idle("clr_wr_timeout");
        Ra_en = 1; Ra_addr = 9;
        step();
        chk("clr_wr_reg9", Ra_data, 16'h0);

        for (int c = 0; c < 400; c++) begin
            W_en    = 1'($urandom_range(0, 1));
            W_addr  = 4'($urandom_range(0, 15));
            W_data  = 16'($urandom);
            Ra_en   = 1'($urandom_range(0, 3) != 0);
            Ra_addr = 4'($urandom_range(0, 15));
            Rb_en   = 1'($urandom_range(0, 3) != 0);
            Rb_addr = ($urandom_range(0, 3) == 0) ? Ra_addr
                                                  : 4'($urandom_range(0, 15));
            Clr     = ($urandom_range(0, 39) == 0);
            step();
        end
        idle_inputs();
        step();
        step();
        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
